// File: rtl/rot_addr_gen.sv
// rot_addr_gen: tile-rotation burst address generator; ROT_AG_STALL_CNT_EN adds a stall counter
module rot_addr_gen #(
  parameter int TILE_LOG2 = 3,
  parameter int BPP = 3,
  parameter int AW = 32,
  parameter int DW = 16,
  parameter int MAX_DIM = 16383
) (
  input  logic          I_AG_HCLK,
  input  logic          I_AG_RESET,
  input  logic          I_AG_START,
  input  logic [DW-1:0] I_AG_HEIGHT,
  input  logic [DW-1:0] I_AG_WIDTH,
  input  logic [1:0]    I_AG_DEGREES,
  input  logic          I_AG_DIRECTION,
  input  logic [AW-1:0] I_AG_SRC_BASE,
  input  logic [AW-1:0] I_AG_DST_BASE,
  input  logic          I_AG_READY,
  output logic          O_AG_VALID,
  output logic [AW-1:0] O_AG_ADDR,
  output logic          O_AG_WRITE,
  output logic [5:0]    O_AG_COUNT,
  output logic [2:0]    O_AG_SIZE,
  output logic [DW-1:0] O_AG_NEW_H,
  output logic [DW-1:0] O_AG_NEW_W,
  output logic          O_AG_BUSY,
  output logic          O_AG_DONE,
  output logic          O_AG_ERR,
  output logic [31:0]   O_AG_STALL_CNT
);
  localparam int T = 1 << TILE_LOG2;
  localparam logic [AW-1:0] TB = AW'(T * BPP);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, state_nx;
  logic [DW-1:0] hp_i, wp_i, wd_i, hd_i, ntx, nty, tx, ty;
  logic [1:0] ang_i, ang;
  logic legal, start_ok, acc, last_row, last_ty, last_tx, gap, err;
  logic [TILE_LOG2-1:0] r;
  logic [AW-1:0] dst0, sstr, dstr, tsrc, tdst, in_step, out_step;
  logic [AW-1:0] rd_col, rd_tile, dst_col, dst_tile, addr, rd_next, dc_next, dt_next;
  logic in_neg, out_neg;
  assign hp_i = (I_AG_HEIGHT + DW'(T - 1)) & ~DW'(T - 1);
  assign wp_i = (I_AG_WIDTH + DW'(T - 1)) & ~DW'(T - 1);
  assign ang_i = I_AG_DIRECTION ? I_AG_DEGREES : 2'd0 - I_AG_DEGREES;
  assign wd_i = ang_i[0] ? hp_i : wp_i;
  assign hd_i = ang_i[0] ? wp_i : hp_i;
  assign legal = I_AG_HEIGHT != '0 && I_AG_WIDTH != '0 &&
                 I_AG_HEIGHT <= DW'(MAX_DIM) && I_AG_WIDTH <= DW'(MAX_DIM);
  assign start_ok = state == IDLE && I_AG_START && legal;
  // first destination tile sits at the far column and/or far row depending on the angle
  assign dst0 = I_AG_DST_BASE
              + ((ang_i[0] ^ ang_i[1]) ? AW'(wd_i - DW'(T)) * AW'(BPP) : '0)
              + (ang_i[1] ? AW'(hd_i - DW'(T)) * AW'(wd_i) * AW'(BPP) : '0);
  assign acc = O_AG_VALID && I_AG_READY;
  assign last_row = &r;
  assign last_ty = ty == nty - DW'(1);
  assign last_tx = tx == ntx - DW'(1);
  assign tsrc = sstr << TILE_LOG2;
  assign tdst = dstr << TILE_LOG2;
  // per-angle destination steps: inner for the next ty, outer for the next tx column
  assign in_step = ang[0] ? TB : tdst;
  assign in_neg = ang[0] ^ ang[1];
  assign out_step = ang[0] ? tdst : TB;
  assign out_neg = ang[1];
  assign rd_next = last_ty ? rd_col + TB : rd_tile + tsrc;
  assign dc_next = dst_col + (out_neg ? AW'(0) - out_step : out_step);
  assign dt_next = last_ty ? dc_next : dst_tile + (in_neg ? AW'(0) - in_step : in_step);
  assign O_AG_VALID = (state == READ || state == WRITE) && !gap;
  assign O_AG_WRITE = state == WRITE;
  assign O_AG_ADDR = addr;
  assign O_AG_BUSY = state != IDLE;
  assign O_AG_DONE = state == DONE;
  assign O_AG_ERR = err;
  assign O_AG_COUNT = 6'(T * BPP / 4);
  assign O_AG_SIZE = 3'h2;
  // state register
  always_ff @(posedge I_AG_HCLK) state <= I_AG_RESET ? IDLE : state_nx;
  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_ok ? READ : IDLE;
      READ:    state_nx = acc && last_row ? WRITE : READ;
      WRITE:   state_nx = acc && last_row ? (last_ty && last_tx ? DONE : READ) : WRITE;
      default: state_nx = IDLE;
    endcase
  end
  // job latch, row/tile counters and incremental address registers
  always_ff @(posedge I_AG_HCLK) begin
    if (I_AG_RESET) begin
      ang <= '0; ntx <= '0; nty <= '0; tx <= '0; ty <= '0; r <= '0;
      O_AG_NEW_H <= '0; O_AG_NEW_W <= '0; sstr <= '0; dstr <= '0;
      rd_col <= '0; rd_tile <= '0; dst_col <= '0; dst_tile <= '0; addr <= '0;
      gap <= 1'b0; err <= 1'b0;
    end else begin
      err <= I_AG_START && state == IDLE && !legal;
      gap <= acc && last_row;
      if (start_ok) begin
        ang <= ang_i;
        ntx <= wp_i >> TILE_LOG2;
        nty <= hp_i >> TILE_LOG2;
        O_AG_NEW_H <= hd_i;
        O_AG_NEW_W <= wd_i;
        sstr <= AW'(wp_i) * AW'(BPP);
        dstr <= AW'(wd_i) * AW'(BPP);
        rd_col <= I_AG_SRC_BASE;
        rd_tile <= I_AG_SRC_BASE;
        addr <= I_AG_SRC_BASE;
        dst_col <= dst0;
        dst_tile <= dst0;
        tx <= '0; ty <= '0; r <= '0;
      end else if (acc) begin
        r <= r + TILE_LOG2'(1);
        if (state == READ) addr <= last_row ? dst_tile : addr + sstr;
        else if (!last_row) addr <= addr + dstr;
        else begin
          addr <= rd_next;
          rd_tile <= rd_next;
          dst_tile <= dt_next;
          ty <= last_ty ? '0 : ty + DW'(1);
          if (last_ty) begin
            tx <= tx + DW'(1);
            rd_col <= rd_next;
            dst_col <= dc_next;
          end
        end
      end
    end
  end
`ifdef ROT_AG_STALL_CNT_EN
  logic [31:0] stall;
  // saturating count of stalled request cycles, cleared per job
  always_ff @(posedge I_AG_HCLK) begin
    if (I_AG_RESET || start_ok) stall <= '0;
    else if (O_AG_VALID && !I_AG_READY && !(&stall)) stall <= stall + 32'd1;
  end
  assign O_AG_STALL_CNT = stall;
`else
  assign O_AG_STALL_CNT = '0;
`endif
endmodule

// File: tb/tb_rot_addr_gen.sv
// tb_rot_addr_gen: directed self-checking bench for rot_addr_gen
module tb_rot_addr_gen;
  logic clk = 1'b0, rst, start, dir, ready, valid, wr, busy, done, err;
  logic [15:0] h, w, new_h, new_w;
  logic [1:0] deg;
  logic [31:0] src, dst, addr, stall;
  logic [5:0] count;
  logic [2:0] size;
  int errors = 0, total = 0;
  rot_addr_gen dut (
    .I_AG_HCLK(clk), .I_AG_RESET(rst), .I_AG_START(start), .I_AG_HEIGHT(h), .I_AG_WIDTH(w),
    .I_AG_DEGREES(deg), .I_AG_DIRECTION(dir), .I_AG_SRC_BASE(src), .I_AG_DST_BASE(dst),
    .I_AG_READY(ready), .O_AG_VALID(valid), .O_AG_ADDR(addr), .O_AG_WRITE(wr),
    .O_AG_COUNT(count), .O_AG_SIZE(size), .O_AG_NEW_H(new_h), .O_AG_NEW_W(new_w),
    .O_AG_BUSY(busy), .O_AG_DONE(done), .O_AG_ERR(err), .O_AG_STALL_CNT(stall)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  task automatic rows(input logic w_ph, input logic [31:0] base, input logic [31:0] stride);
    for (int i = 0; i < 8; i++) begin
      chk("row_valid", 32'(valid), 32'd1);
      chk("row_write", 32'(wr), 32'(w_ph));
      chk("row_addr", addr, base + stride * i);
      step();
    end
  endtask
  task automatic bubble(input logic w_ph);
    chk("bubble_valid", 32'(valid), 32'd0);
    chk("bubble_write", 32'(wr), 32'(w_ph));
    step();
  endtask
  task automatic tile(input logic first, input logic [31:0] rb, input logic [31:0] rs,
                      input logic [31:0] wb, input logic [31:0] ws);
    if (!first) bubble(1'b0);
    rows(1'b0, rb, rs);
    bubble(1'b1);
    rows(1'b1, wb, ws);
  endtask
  task automatic job_end();
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd1);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
  endtask
  task automatic go(input logic [15:0] hh, input logic [15:0] ww, input logic [1:0] dg,
                    input logic dr, input logic [31:0] s, input logic [31:0] d);
    h = hh; w = ww; deg = dg; dir = dr; src = s; dst = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; h = 16'd8; w = 16'd8; deg = 2'd0; dir = 1'b1;
    src = '0; dst = '0; ready = 1'b1;
    step();
    step();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_write", 32'(wr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_new_h", 32'(new_h), 32'd0);
    chk("rst_new_w", 32'(new_w), 32'd0);
    chk("rst_stall", stall, 32'd0);
    chk("count", 32'(count), 32'd6);
    chk("size", 32'(size), 32'd2);
    rst = 1'b0;
    start = 1'b1;
    rst = 1'b1;
    step();
    chk("start_in_reset_busy", 32'(busy), 32'd0);
    rst = 1'b0; start = 1'b0;
    // 8x8, 0 deg; START held and inputs changed mid-job must be ignored
    h = 16'd8; w = 16'd8; deg = 2'd0; dir = 1'b1; src = 32'h0; dst = 32'h1000; start = 1'b1;
    step();
    h = 16'd16; dst = 32'h5000; deg = 2'd1;
    chk("j1_busy", 32'(busy), 32'd1);
    chk("j1_new_h", 32'(new_h), 32'd8);
    chk("j1_new_w", 32'(new_w), 32'd8);
    rows(1'b0, 32'h0, 32'd24);
    start = 1'b0;
    bubble(1'b1);
    rows(1'b1, 32'h1000, 32'd24);
    job_end();
    chk("j1_new_h_held", 32'(new_h), 32'd8);
    // 16x8 rotated 90 clockwise
    go(16'd16, 16'd8, 2'd1, 1'b1, 32'h2000, 32'h3000);
    chk("j2_new_w", 32'(new_w), 32'd16);
    chk("j2_new_h", 32'(new_h), 32'd8);
    tile(1'b1, 32'h2000, 32'd24, 32'h3000 + 32'd24, 32'd48);
    tile(1'b0, 32'h2000 + 32'd192, 32'd24, 32'h3000, 32'd48);
    job_end();
    // 5x10 padded, 0 deg via counter-clockwise
    go(16'd5, 16'd10, 2'd0, 1'b0, 32'h0, 32'h800);
    chk("j3_new_h", 32'(new_h), 32'd8);
    chk("j3_new_w", 32'(new_w), 32'd16);
    tile(1'b1, 32'h0, 32'd48, 32'h800, 32'd48);
    tile(1'b0, 32'd24, 32'd48, 32'h800 + 32'd24, 32'd48);
    job_end();
    // 8x16, counter-clockwise 90 -> effective 270
    go(16'd8, 16'd16, 2'd1, 1'b0, 32'h100, 32'h4000);
    chk("j4_new_h", 32'(new_h), 32'd16);
    chk("j4_new_w", 32'(new_w), 32'd8);
    tile(1'b1, 32'h100, 32'd48, 32'h4000 + 32'd192, 32'd24);
    tile(1'b0, 32'h100 + 32'd24, 32'd48, 32'h4000, 32'd24);
    job_end();
    // 8x16, counter-clockwise 180
    go(16'd8, 16'd16, 2'd2, 1'b0, 32'h0, 32'h6000);
    chk("j5_new_h", 32'(new_h), 32'd8);
    chk("j5_new_w", 32'(new_w), 32'd16);
    tile(1'b1, 32'h0, 32'd48, 32'h6000 + 32'd24, 32'd48);
    tile(1'b0, 32'd24, 32'd48, 32'h6000, 32'd48);
    job_end();
    // back-pressure on the second read, then reset during the fourth write
    go(16'd8, 16'd8, 2'd0, 1'b1, 32'h0, 32'h1000);
    chk("s_addr0", addr, 32'd0);
    step();
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("s_hold_valid", 32'(valid), 32'd1);
      chk("s_hold_addr", addr, 32'd24);
      step();
    end
    ready = 1'b1;
    chk("s_hold_addr4", addr, 32'd24);
    step();
`ifdef ROT_AG_STALL_CNT_EN
    chk("s_stall_cnt", stall, 32'd3);
`else
    chk("s_stall_cnt", stall, 32'd0);
`endif
    for (int i = 2; i < 8; i++) begin
      chk("s_read_addr", addr, 32'd24 * i);
      step();
    end
    bubble(1'b1);
    for (int i = 0; i < 3; i++) step();
    chk("s_w4_addr", addr, 32'h1000 + 32'd72);
    chk("s_w4_valid", 32'(valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_addr", addr, 32'd0);
    chk("mid_rst_write", 32'(wr), 32'd0);
    chk("mid_rst_stall", stall, 32'd0);
    chk("mid_rst_new_w", 32'(new_w), 32'd0);
    // illegal dimensions
    go(16'd8, 16'd0, 2'd0, 1'b1, 32'h0, 32'h0);
    chk("err_w0", 32'(err), 32'd1);
    chk("err_w0_busy", 32'(busy), 32'd0);
    step();
    chk("err_w0_pulse", 32'(err), 32'd0);
    chk("err_w0_idle", 32'(busy), 32'd0);
    go(16'd16384, 16'd8, 2'd0, 1'b1, 32'h0, 32'h0);
    chk("err_hmax", 32'(err), 32'd1);
    chk("err_hmax_busy", 32'(busy), 32'd0);
    go(16'd16383, 16'd8, 2'd0, 1'b1, 32'h0, 32'h0);
    chk("max_ok_err", 32'(err), 32'd0);
    chk("max_ok_busy", 32'(busy), 32'd1);
    chk("max_ok_new_h", 32'(new_h), 32'd16384);
    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end
endmodule

// File: doc/rot_addr_gen.md
ROT_ADDR_GEN -- requirements
Module: rot_addr_gen

Interface
REQ-001 Parameter TILE_LOG2, default 3, sets tile edge T = 2^TILE_LOG2 pixels (legal 2..5).
REQ-002 Parameter BPP, default 3, sets bytes per pixel; T*BPP SHALL be a multiple of 4.
REQ-003 Parameter AW, default 32, sets the address width.
REQ-004 Parameter DW, default 16, sets the image-dimension width.
REQ-005 Parameter MAX_DIM, default 16383, sets the largest legal H or W.
REQ-006 I_AG_HCLK  in  1  single clock; all logic is on its rising edge.
REQ-007 I_AG_RESET  in  1  synchronous reset, active-high.
REQ-008 I_AG_START  in  1  job start, sampled in IDLE only.
REQ-009 I_AG_HEIGHT, I_AG_WIDTH  in  DW each  source image size in pixels.
REQ-010 I_AG_DEGREES  in  2  rotation amount: 0/90/180/270; I_AG_DIRECTION  in  1  1=clockwise, 0=counter-clockwise.
REQ-011 I_AG_SRC_BASE, I_AG_DST_BASE  in  AW each  byte base addresses.
REQ-012 I_AG_READY  in  1  bus accepts the current request.
REQ-013 O_AG_VALID  out  1  request valid; O_AG_ADDR  out  AW  burst start byte address; O_AG_WRITE  out  1  0=read row, 1=write row.
REQ-014 O_AG_COUNT  out  6  beats per burst = T*BPP/4 (constant); O_AG_SIZE  out  3  fixed 3'h2 (32-bit).
REQ-015 O_AG_NEW_H, O_AG_NEW_W  out  DW each  padded destination height/width in pixels.
REQ-016 O_AG_BUSY  out  1; O_AG_DONE  out  1  one-cycle pulse; O_AG_ERR  out  1  one-cycle pulse.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE, DONE; IDLE->READ on START with legal dims, READ->WRITE after the T-th read is accepted, WRITE->READ after the T-th write if tiles remain, otherwise WRITE->DONE, and DONE->IDLE unconditionally.
REQ-018 On START in IDLE, H, W, the effective angle, and both bases SHALL be latched; input changes during the job SHALL be ignored.
REQ-019 Hp and Wp are H and W rounded up to a multiple of T; nTx = Wp/T and nTy = Hp/T.
REQ-020 The effective clockwise angle is DEGREES when DIRECTION=1 and (4-DEGREES) mod 4 when DIRECTION=0.
REQ-021 For angle 0/180: Wd=Wp, Hd=Hp; for 90/270: Wd=Hp, Hd=Wp; O_AG_NEW_W=Wd and O_AG_NEW_H=Hd, updated at latch and held until the next START.
REQ-022 Tiles (tx,ty) SHALL be visited with ty inner (0..nTy-1) and tx outer (0..nTx-1).
REQ-023 Read row r (0..T-1) of a tile SHALL address SRC_BASE + (ty*T+r)*Wp*BPP + tx*T*BPP.
REQ-024 The destination tile (dx,dy) SHALL be: 0:(tx,ty); 90:(nTy-1-ty, tx); 180:(nTx-1-tx, nTy-1-ty); 270:(ty, nTx-1-tx).
REQ-025 Write row r of a tile SHALL address DST_BASE + (dy*T+r)*Wd*BPP + dx*T*BPP; reordering pixels within the tile is outside this block.
REQ-026 Addresses SHALL be formed with latched stride registers and incremental adds, with no per-cycle multiplier, and SHALL wrap modulo 2^AW.
REQ-027 O_AG_VALID SHALL be high throughout READ and WRITE except for the cycle after an acceptance that ends a phase; a request is accepted when VALID&&READY.
REQ-028 ADDR and WRITE SHALL stay stable while VALID&&!READY, and the next row SHALL be presented the cycle after acceptance.
REQ-029 If H=0, W=0, H>MAX_DIM or W>MAX_DIM at START, the block SHALL pulse O_AG_ERR for one cycle and stay in IDLE.
REQ-030 BUSY SHALL be 1 in READ/WRITE/DONE; DONE SHALL pulse in state DONE.
REQ-031 START while not IDLE SHALL be ignored; START coincident with RESET SHALL be ignored.

Reset
REQ-032 RESET SHALL force IDLE on the next edge from any state, including mid-burst.
REQ-033 Reset values: VALID=0, ADDR=0, WRITE=0, BUSY=0, DONE=0, ERR=0, NEW_H=0, NEW_W=0, all counters 0.

Configuration
REQ-034 With ROT_AG_STALL_CNT_EN defined, output O_AG_STALL_CNT (32 bits) SHALL count cycles with VALID&&!READY, clear on START acceptance and on RESET, and saturate at all-ones.
REQ-035 Without ROT_AG_STALL_CNT_EN, O_AG_STALL_CNT SHALL exist and be tied to 0.

Verification
REQ-036 H=W=8, deg 0, SRC=0, DST=0x1000, READY=1 -> reads 0,24,..,168, then writes 0x1000,0x1018,..,0x10A8, then DONE; COUNT=6.
REQ-037 H=16, W=8, DEGREES=1, DIRECTION=1 -> NEW_W=16, NEW_H=8; tile (0,0) writes DST+r*48+24; tile (0,1) writes DST+r*48.
REQ-038 H=5, W=10, deg 0 -> NEW_H=8, NEW_W=16; 2 tiles; the second tile reads at 24+r*48.
REQ-039 READY held low 3 cycles on the 2nd read -> ADDR=24 held for 4 cycles; STALL_CNT=3 when the macro is defined.
REQ-040 RESET asserted during the 4th write -> next cycle VALID=0, BUSY=0; W=0 at START -> single ERR pulse, BUSY stays 0.
